// File: rtl/popcount27_stimgen.sv
// popcount27_stimgen: stimulus source for 27-input approximate popcount units.
// Accepts a request (count k, number n) and streams n 27-bit vectors, each
// holding exactly k set bits rotated by an LFSR-derived offset. The expected
// count (exp_count) travels with each vector.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  request handshake; req_count = k (clamped to 27),
//                        req_num = n vectors
//   vec_valid/vec_ready  vector handshake; vec_data, vec_last (final vector)
//   exp_count            latched k, held until the next request acceptance
//   done                 one-cycle pulse when a request completes
//   err                  sticky self-check failure
//
// Optional feature macro: POPCOUNT27_STIMGEN_CHECK_EN builds an exact popcount
// checker on vec_data; without it err is tied to 0.
module popcount27_stimgen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_count,
  input  logic [15:0] req_num,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [26:0] vec_data,
  output logic        vec_last,
  output logic [4:0]  exp_count,
  output logic        done,
  output logic        err
);

  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [4:0]  k_q, k_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [26:0] data_q, data_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic        accept, fire;
  logic [4:0]  k_in;
  logic [15:0] lfsr_nxt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // rotl27((1<<k)-1, off): rotation done by shifting a doubled copy so the
  // bits falling off the top re-enter at the bottom.
  function automatic logic [26:0] make_vec(input logic [4:0] k, input logic [15:0] s);
    logic [4:0]  off;
    logic [27:0] m;
    logic [53:0] dbl;
    off = (s[4:0] < 5'd27) ? s[4:0] : s[4:0] - 5'd27;
    m   = (28'd1 << k) - 28'd1;
    dbl = {m[26:0], m[26:0]} << off;
    return dbl[53:27];
  endfunction

  assign accept   = req_valid && req_ready;
  assign fire     = valid_q && vec_ready;
  assign k_in     = (req_count > 5'd27) ? 5'd27 : req_count;
  assign lfsr_nxt = lfsr_step(lfsr_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && (req_num != 16'd0)) state_d = RUN;
      RUN:  if (fire && (rem_q == 16'd1))     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the only unregistered output.
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
  end

  // Datapath next-state
  always_comb begin
    k_d     = k_q;
    rem_d   = rem_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (accept) begin
      k_d    = k_in;
      rem_d  = req_num;
      done_d = (req_num == 16'd0);
      if (req_num != 16'd0) begin
        valid_d = 1'b1;
        data_d  = make_vec(k_in, lfsr_q);
        last_d  = (req_num == 16'd1);
      end
    end else if (fire) begin
      rem_d  = rem_q - 16'd1;
      lfsr_d = lfsr_nxt;
      if (rem_q == 16'd1) begin
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        data_d = make_vec(k_q, lfsr_nxt);
        last_d = (rem_q == 16'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      rem_q   <= '0;
      lfsr_q  <= SEED_EFF;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      rem_q   <= rem_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign vec_valid = valid_q;
  assign vec_data  = data_q;
  assign vec_last  = last_q;
  assign exp_count = k_q;
  assign done      = done_q;

`ifdef POPCOUNT27_STIMGEN_CHECK_EN
  logic err_q, err_d;
  logic mismatch;

  function automatic logic [4:0] popcount27(input logic [26:0] v);
    logic [4:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < 27; i++) sum = sum + {4'd0, v[i]};
    return sum;
  endfunction

  assign mismatch = valid_q && (popcount27(data_q) != k_q);

  always_comb begin
    err_d = err_q | mismatch;
    if (accept) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_popcount27_stimgen.sv
module tb_popcount27_stimgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_count;
  logic [15:0] req_num;
  logic        vec_valid;
  logic        vec_ready;
  logic [26:0] vec_data;
  logic        vec_last;
  logic [4:0]  exp_count;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  popcount27_stimgen #(.SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_count (req_count),
    .req_num   (req_num),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_last  (vec_last),
    .exp_count (exp_count),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] k, input logic [15:0] n);
    req_valid = 1'b1;
    req_count = k;
    req_num   = n;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_count = '0; req_num = '0; vec_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    // k=5, n=3, streaming: lfsr ACE1 -> E270 -> 7138
    vec_ready = 1'b1;
    req(5, 3);
    chk("s1_valid", {31'd0, vec_valid}, 32'd1);
    chk("s1_ready_low", {31'd0, req_ready}, 32'd0);
    chk("s1_exp", {27'd0, exp_count}, 32'd5);
    chk("s1_v0", {5'd0, vec_data}, 32'h000003E);
    chk("s1_last0", {31'd0, vec_last}, 32'd0);
    tick();
    chk("s1_v1", {5'd0, vec_data}, 32'h01F0000);
    chk("s1_last1", {31'd0, vec_last}, 32'd0);
    tick();
    chk("s1_v2", {5'd0, vec_data}, 32'h7000003);
    chk("s1_last2", {31'd0, vec_last}, 32'd1);
    chk("s1_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("s1_done", {31'd0, done}, 32'd1);
    chk("s1_idle_valid", {31'd0, vec_valid}, 32'd0);
    chk("s1_idle_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("s1_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure: k=5, n=2; lfsr 389C (off 1) then 1C4E (off 14)
    vec_ready = 1'b0;
    req(5, 2);
    chk("bp_v0", {5'd0, vec_data}, 32'h000003E);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", {5'd0, vec_data}, 32'h000003E);
      chk("bp_hold_valid", {31'd0, vec_valid}, 32'd1);
      chk("bp_hold_last", {31'd0, vec_last}, 32'd0);
      chk("bp_hold_exp", {27'd0, exp_count}, 32'd5);
      chk("bp_lfsr", {16'd0, dut.lfsr_q}, 32'h389C);
    end
    vec_ready = 1'b1;
    tick();
    chk("bp_v1", {5'd0, vec_data}, 32'h007C000);
    chk("bp_last1", {31'd0, vec_last}, 32'd1);
    tick();
    chk("bp_done", {31'd0, done}, 32'd1);

    // New request accepted while done is high: k=0, n=2
    req(0, 2);
    chk("k0_exp", {27'd0, exp_count}, 32'd0);
    chk("k0_valid", {31'd0, vec_valid}, 32'd1);
    chk("k0_v0", {5'd0, vec_data}, 32'h0000000);
    tick();
    chk("k0_v1", {5'd0, vec_data}, 32'h0000000);
    chk("k0_last", {31'd0, vec_last}, 32'd1);
    tick();
    chk("k0_done", {31'd0, done}, 32'd1);

    // k=27, n=1
    req(27, 1);
    chk("k27_v", {5'd0, vec_data}, 32'h7FFFFFF);
    chk("k27_last", {31'd0, vec_last}, 32'd1);
    chk("k27_exp", {27'd0, exp_count}, 32'd27);
    tick();
    chk("k27_done", {31'd0, done}, 32'd1);

    // Clamp: req_count=30
    req(30, 1);
    chk("clamp_exp", {27'd0, exp_count}, 32'd27);
    chk("clamp_v", {5'd0, vec_data}, 32'h7FFFFFF);
    tick();
    chk("clamp_done", {31'd0, done}, 32'd1);
    tick();

    // req_num = 0
    req(9, 0);
    chk("n0_done", {31'd0, done}, 32'd1);
    chk("n0_valid", {31'd0, vec_valid}, 32'd0);
    chk("n0_exp", {27'd0, exp_count}, 32'd9);
    tick();
    chk("n0_done_pulse", {31'd0, done}, 32'd0);
    chk("n0_valid2", {31'd0, vec_valid}, 32'd0);

    // Reset mid-request: k=3, n=5; lfsr 6162 (off 2), 30B1 (off 17)
    req(3, 5);
    chk("mr_v0", {5'd0, vec_data}, 32'h000001C);
    tick();
    chk("mr_v1", {5'd0, vec_data}, 32'h00E0000);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_rst_valid", {31'd0, vec_valid}, 32'd0);
    chk("mr_rst_data", {5'd0, vec_data}, 32'd0);
    chk("mr_rst_last", {31'd0, vec_last}, 32'd0);
    chk("mr_rst_exp", {27'd0, exp_count}, 32'd0);
    chk("mr_rst_done", {31'd0, done}, 32'd0);
    chk("mr_rst_err", {31'd0, err}, 32'd0);
    chk("mr_rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_done", {31'd0, done}, 32'd0);
    end
    req(5, 1);
    chk("mr_restart_v", {5'd0, vec_data}, 32'h000003E);
    tick();
    chk("mr_restart_done", {31'd0, done}, 32'd1);
    tick();

`ifdef POPCOUNT27_STIMGEN_CHECK_EN
    for (int k = 0; k < 28; k++) begin
      req(5'(k), 16'd36);
      wait_done("chk_sweep_done");
      tick();
    end
    chk("chk_sweep_err", {31'd0, err}, 32'd0);
    begin
      logic [26:0] bad;
      vec_ready = 1'b0;
      req(5, 4);
      bad = vec_data ^ 27'h0000001;
      force dut.data_q = bad;
      tick();
      release dut.data_q;
      chk("chk_flip_err", {31'd0, err}, 32'd1);
      vec_ready = 1'b1;
      wait_done("chk_flip_drain");
      tick();
      chk("chk_sticky_err", {31'd0, err}, 32'd1);
      req(5, 0);
      chk("chk_clear_err", {31'd0, err}, 32'd0);
    end
`else
    chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount27_stimgen.md
# popcount27_stimgen

Sequential stimulus source for the 27-input approximate popcount units. Accepts a request `(count k, number n)` and streams n 27-bit input vectors, each with exactly k bits set, over a valid/ready interface. The expected count travels alongside each vector, so a downstream comparator can measure MAE, WCE and error probability of the approximate popcount under test. It sits on the evaluation side of the popcount datapath: it turns a count into bit vectors, the inverse of what the popcount does.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clk  in  1`: the single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: block can accept a request.
- `req_count  in  5`: target popcount k. Values above 27 are clamped to 27.
- `req_num  in  16`: number of vectors n to emit.
- `vec_valid  out  1`: vector present.
- `vec_ready  in  1`: consumer accepts the vector.
- `vec_data  out  27`: stimulus vector.
- `vec_last  out  1`: marks the final vector of a request.
- `exp_count  out  5`: latched k (after clamping).
- `done  out  1`: one-cycle pulse when a request completes.
- `err  out  1`: self-check failure, sticky. Present only with the macro; otherwise tied 0.

## Operation
- FSM states are IDLE and RUN.
- **IDLE**
  - `req_ready=1`, `vec_valid=0`.
  - On `req_valid&req_ready`: latch `k=min(req_count,27)` and `rem=req_num`.
  - If `req_num==0`: stay in IDLE and pulse `done` next cycle.
  - Otherwise: go to RUN and load the first vector.
- **RUN**
  - `req_ready=0`, `vec_valid=1`.
  - `vec_data = rotl27(mask_k, off)`, where `mask_k = (1<<k)-1` over 27 bits. k=0 gives all zeros; k=27 gives 27'h7FFFFFF.
  - `off = lfsr[4:0]` if `<27`, else `lfsr[4:0]-27`. Range is 0..26.
  - `vec_last = (rem==1)`.
  - On `vec_valid&vec_ready`:
    - `rem` decrements.
    - LFSR advances one step.
    - The next vector is registered.
    - If that was the last vector: go to IDLE and pulse `done` in the following cycle.
- **LFSR**
  - 16-bit Galois, mask 16'hB400.
  - Step: `lfsr = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances only on vector handshakes. It is not reloaded on new requests, so the sequence continues across requests.
- `exp_count` holds k from request acceptance until the next acceptance.
- **Reset** (mid-operation included), at the next edge with `rst=1`:
  - State goes to IDLE; `rem=0`; `lfsr=SEED`.
  - Outputs: `req_ready=0` during reset and 1 from the first cycle after. `vec_valid=0`, `vec_data=0`, `vec_last=0`, `exp_count=0`, `done=0`, `err=0`.
  - Any request in flight is dropped without a `done` pulse.

## Timing
- Request accepted at edge t → `vec_valid=1` with the first vector from t+1.
- Throughput is one vector per cycle while `vec_ready=1`.
- Backpressure: while `vec_valid&!vec_ready`, `vec_data`, `vec_last` and `exp_count` hold stable.
- Final handshake at edge t → `done=1` during cycle t+1, and `req_ready=1` in that same cycle.
- A new request may be accepted in the cycle `done` is high.
- `req_num==0` accepted at t → `done` during t+1 with no vector emitted.
- All outputs are registered, except `req_ready`, which decodes directly from state.

## Configuration
- `POPCOUNT27_STIMGEN_CHECK_EN`
  - **Defined:** an exact 27-bit popcount (adder tree) of `vec_data` is compared against `exp_count` on every cycle with `vec_valid=1`. A mismatch sets `err`, registered one cycle later. `err` clears on reset or on the next request acceptance.
  - **Undefined:** the checker is not built and `err` is constant 0.
  - Stream behaviour is identical in both builds.

## Test plan
- Reset with `SEED` default, then release → `req_ready=1`, `vec_valid=0`, `done=0`, `err=0`.
- Request k=5, n=3 with `vec_ready=1`:
  - Vectors are 27'h000003E (off 1, lfsr 16'hACE1), then 27'h01F0000 (off 16, lfsr 16'hE270), then a third vector with 5 ones.
  - `vec_last` is set only on the third; `done` pulses one cycle after it.
- Backpressure: k=5, n=2 with `vec_ready=0` for 4 cycles → first vector 27'h000003E held stable for 4 cycles and the LFSR does not advance. Raising `vec_ready` releases it.
- Boundary counts:
  - k=0, n=2 → two vectors of 27'h0000000.
  - k=27, n=1 → 27'h7FFFFFF with `vec_last=1`.
  - `req_count=30` → clamped; `exp_count=27` and vector 27'h7FFFFFF.
- `req_num=0` → `done` the next cycle with no `vec_valid`. Also: `rst` asserted after the second of 5 vectors → all outputs 0, no `done`, and the next request restarts from lfsr 16'hACE1.
- With `POPCOUNT27_STIMGEN_CHECK_EN`, run 1000 vectors over k=0..27 → `err` stays 0. Force a bit flip on `vec_data` in the bench → `err=1` the next cycle, sticky until the next request.
